// File: rtl/control_configuracion.sv
// rtl/control_configuracion.sv - mode FSM, field cursor and edit strobes for clock/date/timer configuration
// Optional feature macro: AUTOREPEAT_EN (held UP/DOWN repeats inc/dec strobes)
module control_configuracion #(
  parameter int REPEAT_DELAY = 50_000_000,
  parameter int REPEAT_RATE  = 10_000_000,
  parameter int CNT_W        = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] sw_db,
  input  logic [4:0] btn_db,
  output logic [1:0] modo,
  output logic [1:0] campo,
  output logic       inc,
  output logic       dec,
  output logic       guardar,
  output logic       formato_12h,
  output logic       editando
);

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    CFG_HORA  = 2'd1,
    CFG_FECHA = 2'd2,
    CFG_TIMER = 2'd3
  } modo_e;

  modo_e      modo_q, modo_d;
  logic [1:0] campo_q, campo_d;
  logic       inc_q, inc_d;
  logic       dec_q, dec_d;
  logic       guardar_q, guardar_d;
  logic       formato_q;
  logic       editando_q;
  logic [4:0] btn_prev_q;

  logic [4:0] btn_edge;
  logic       cambio_modo;
  logic       activo;
  logic       up_ok, dn_ok, sav_ok;
  logic       rep_inc, rep_dec;

  assign btn_edge = btn_db & ~btn_prev_q;

  // Previous button levels; loaded even in reset so a held button never looks like a fresh press
  always_ff @(posedge clk) begin
    btn_prev_q <= btn_db;
  end

  // Mode FSM next state: NORMAL picks the highest-priority switch, CFG states leave only on their own switch
  always_comb begin
    modo_d = modo_q;
    unique case (modo_q)
      NORMAL: begin
        if (sw_db[0])      modo_d = CFG_HORA;
        else if (sw_db[1]) modo_d = CFG_FECHA;
        else if (sw_db[2]) modo_d = CFG_TIMER;
      end
      CFG_HORA:  if (!sw_db[0]) modo_d = NORMAL;
      CFG_FECHA: if (!sw_db[1]) modo_d = NORMAL;
      CFG_TIMER: if (!sw_db[2]) modo_d = NORMAL;
    endcase
  end

  // Edges only count in a CFG state that is not changing this cycle; a save edge wins over inc/dec
  always_comb begin
    cambio_modo = (modo_d != modo_q);
    activo      = (modo_q != NORMAL) && !cambio_modo;
    sav_ok      = activo && btn_edge[4];
    up_ok       = activo && btn_edge[0] && !btn_edge[1] && !sav_ok;
    dn_ok       = activo && btn_edge[1] && !btn_edge[0] && !sav_ok;
    inc_d       = up_ok | rep_inc;
    dec_d       = dn_ok | rep_dec;
    guardar_d   = sav_ok;
  end

  // Field cursor: cleared whenever NORMAL is (re)entered, wraps over 0..2, opposing edges cancel
  always_comb begin
    campo_d = campo_q;
    if (modo_d == NORMAL) begin
      campo_d = 2'd0;
    end else if (activo) begin
      if (btn_edge[3] && !btn_edge[2]) begin
        campo_d = (campo_q == 2'd2) ? 2'd0 : campo_q + 2'd1;
      end else if (btn_edge[2] && !btn_edge[3]) begin
        campo_d = (campo_q == 2'd0) ? 2'd2 : campo_q - 2'd1;
      end
    end
  end

`ifdef AUTOREPEAT_EN
  // Repeat counter is armed (non-zero) only after a real UP/DOWN strobe and counts while that button is held alone
  logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_fase_q, rep_fase_d;
  logic [CNT_W-1:0] umbral;
  logic             mantiene;

  // Next repeat count: first wait REPEAT_DELAY, then REPEAT_RATE between repeats
  always_comb begin
    rep_cnt_d  = '0;
    rep_fase_d = 1'b0;
    rep_inc    = 1'b0;
    rep_dec    = 1'b0;
    umbral     = rep_fase_q ? CNT_W'(REPEAT_RATE) : CNT_W'(REPEAT_DELAY);
    mantiene   = activo && (btn_db[0] ^ btn_db[1]) && !btn_edge[0] && !btn_edge[1];
    if (up_ok || dn_ok) begin
      rep_cnt_d = CNT_W'(1);
    end else if (mantiene && (rep_cnt_q != '0)) begin
      if (rep_cnt_q == umbral) begin
        rep_cnt_d  = CNT_W'(1);
        rep_fase_d = 1'b1;
        rep_inc    = btn_db[0] && !sav_ok;
        rep_dec    = btn_db[1] && !sav_ok;
      end else begin
        rep_cnt_d  = rep_cnt_q + CNT_W'(1);
        rep_fase_d = rep_fase_q;
      end
    end
  end

  // Repeat counter state
  always_ff @(posedge clk) begin
    if (reset) begin
      rep_cnt_q  <= '0;
      rep_fase_q <= 1'b0;
    end else begin
      rep_cnt_q  <= rep_cnt_d;
      rep_fase_q <= rep_fase_d;
    end
  end
`else
  logic unused_params;
  assign unused_params = ^{REPEAT_DELAY, REPEAT_RATE, CNT_W};
  assign rep_inc = 1'b0;
  assign rep_dec = 1'b0;
`endif

  // Registered outputs and mode state
  always_ff @(posedge clk) begin
    if (reset) begin
      modo_q     <= NORMAL;
      campo_q    <= 2'd0;
      inc_q      <= 1'b0;
      dec_q      <= 1'b0;
      guardar_q  <= 1'b0;
      formato_q  <= 1'b0;
      editando_q <= 1'b0;
    end else begin
      modo_q     <= modo_d;
      campo_q    <= campo_d;
      inc_q      <= inc_d;
      dec_q      <= dec_d;
      guardar_q  <= guardar_d;
      formato_q  <= sw_db[3];
      editando_q <= (modo_d != NORMAL);
    end
  end

  assign modo        = modo_q;
  assign campo       = campo_q;
  assign inc         = inc_q;
  assign dec         = dec_q;
  assign guardar     = guardar_q;
  assign formato_12h = formato_q;
  assign editando    = editando_q;

endmodule

// File: tb/tb_control_configuracion.sv
// tb/tb_control_configuracion.sv - vector-table bench for control_configuracion
module tb_control_configuracion;

  localparam int RD = 8;
  localparam int RR = 3;
`ifdef AUTOREPEAT_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] sw_db;
  logic [4:0] btn_db;
  logic [1:0] modo, campo;
  logic       inc, dec, guardar, formato_12h, editando;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    logic       rst;
    logic [3:0] sw;
    logic [4:0] btn;
    logic [8:0] exp;
  } vec_t;

  vec_t tbl[$];

  control_configuracion #(
    .REPEAT_DELAY(RD),
    .REPEAT_RATE (RR),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sw_db      (sw_db),
    .btn_db     (btn_db),
    .modo       (modo),
    .campo      (campo),
    .inc        (inc),
    .dec        (dec),
    .guardar    (guardar),
    .formato_12h(formato_12h),
    .editando   (editando)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] ex(input logic [1:0] m, input logic [1:0] c, input logic i,
                                    input logic d, input logic g, input logic f, input logic e);
    return {m, c, i, d, g, f, e};
  endfunction

  task automatic add(input logic r, input logic [3:0] s, input logic [4:0] b, input logic [8:0] e);
    vec_t v;
    v.rst = r;
    v.sw  = s;
    v.btn = b;
    v.exp = e;
    tbl.push_back(v);
  endtask

  task automatic step(input logic r, input logic [3:0] s, input logic [4:0] b);
    reset  = r;
    sw_db  = s;
    btn_db = b;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [8:0] e);
    logic [8:0] act;
    act = {modo, campo, inc, dec, guardar, formato_12h, editando};
    n_total++;
    if (act === e) n_pass++;
    else $display("FAIL %s: got {modo,campo,inc,dec,sav,fmt,edit}=%b expected %b", nm, act, e);
  endtask

  initial begin
    reset  = 1'b1;
    sw_db  = 4'd0;
    btn_db = 5'b00001;

    // reset with UP held, then release
    add(1, 4'd0, 5'd1,  ex(0,0,0,0,0,0,0));
    add(1, 4'd0, 5'd1,  ex(0,0,0,0,0,0,0));
    add(0, 4'd0, 5'd1,  ex(0,0,0,0,0,0,0));
    add(0, 4'd0, 5'd0,  ex(0,0,0,0,0,0,0));
    // priority and exit through NORMAL
    add(0, 4'd3, 5'd0,  ex(1,0,0,0,0,0,1));
    add(0, 4'd3, 5'd0,  ex(1,0,0,0,0,0,1));
    add(0, 4'd2, 5'd0,  ex(0,0,0,0,0,0,0));
    add(0, 4'd2, 5'd0,  ex(2,0,0,0,0,0,1));
    add(0, 4'd0, 5'd0,  ex(0,0,0,0,0,0,0));
    // cursor in CFG_HORA
    add(0, 4'd1, 5'd0,  ex(1,0,0,0,0,0,1));
    add(0, 4'd1, 5'd8,  ex(1,1,0,0,0,0,1));
    add(0, 4'd1, 5'd0,  ex(1,1,0,0,0,0,1));
    add(0, 4'd1, 5'd8,  ex(1,2,0,0,0,0,1));
    add(0, 4'd1, 5'd0,  ex(1,2,0,0,0,0,1));
    add(0, 4'd1, 5'd8,  ex(1,0,0,0,0,0,1));
    add(0, 4'd1, 5'd0,  ex(1,0,0,0,0,0,1));
    add(0, 4'd1, 5'd4,  ex(1,2,0,0,0,0,1));
    add(0, 4'd1, 5'd0,  ex(1,2,0,0,0,0,1));
    add(0, 4'd1, 5'd12, ex(1,2,0,0,0,0,1));
    add(0, 4'd1, 5'd0,  ex(1,2,0,0,0,0,1));
    add(0, 4'd1, 5'd4,  ex(1,1,0,0,0,0,1));
    add(0, 4'd1, 5'd0,  ex(1,1,0,0,0,0,1));
    add(0, 4'd0, 5'd0,  ex(0,0,0,0,0,0,0));
    // strobes in CFG_TIMER; UP edge on the mode-change cycle is dropped
    add(0, 4'd4, 5'd1,  ex(3,0,0,0,0,0,1));
    add(0, 4'd4, 5'd0,  ex(3,0,0,0,0,0,1));
    add(0, 4'd4, 5'd1,  ex(3,0,1,0,0,0,1));
    add(0, 4'd4, 5'd1,  ex(3,0,0,0,0,0,1));
    add(0, 4'd4, 5'd0,  ex(3,0,0,0,0,0,1));
    add(0, 4'd4, 5'd2,  ex(3,0,0,1,0,0,1));
    add(0, 4'd4, 5'd0,  ex(3,0,0,0,0,0,1));
    add(0, 4'd4, 5'd16, ex(3,0,0,0,1,0,1));
    add(0, 4'd4, 5'd0,  ex(3,0,0,0,0,0,1));
    add(0, 4'd4, 5'd3,  ex(3,0,0,0,0,0,1));
    add(0, 4'd4, 5'd0,  ex(3,0,0,0,0,0,1));
    // 12h format follows sw[3]; UP in NORMAL gives nothing
    add(0, 4'd12, 5'd0, ex(3,0,0,0,0,1,1));
    add(0, 4'd8, 5'd0,  ex(0,0,0,0,0,1,0));
    add(0, 4'd8, 5'd1,  ex(0,0,0,0,0,1,0));
    add(0, 4'd8, 5'd0,  ex(0,0,0,0,0,1,0));
    add(0, 4'd0, 5'd0,  ex(0,0,0,0,0,0,0));
    // reset in the middle of editing
    add(0, 4'd4, 5'd0,  ex(3,0,0,0,0,0,1));
    add(0, 4'd4, 5'd8,  ex(3,1,0,0,0,0,1));
    add(1, 4'd12, 5'd0, ex(0,0,0,0,0,0,0));
    add(0, 4'd4, 5'd0,  ex(3,0,0,0,0,0,1));
    add(0, 4'd0, 5'd0,  ex(0,0,0,0,0,0,0));

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].sw, tbl[i].btn);
      chk($sformatf("vec%0d", i), tbl[i].exp);
    end

    // UP held 20 cycles in CFG_FECHA
    step(0, 4'd2, 5'd0);
    chk("fecha_enter", ex(2,0,0,0,0,0,1));
    step(0, 4'd2, 5'd0);
    chk("fecha_idle", ex(2,0,0,0,0,0,1));
    for (int k = 0; k < 20; k++) begin
      logic e_inc;
      e_inc = (k == 0) || (AR && (k == RD || k == RD + RR || k == RD + 2*RR || k == RD + 3*RR));
      step(0, 4'd2, 5'd1);
      chk($sformatf("hold_rel%0d", k + 1), ex(2,0,e_inc,0,0,0,1));
    end
    step(0, 4'd10, 5'd0);
    chk("fecha_fmt_on", ex(2,0,0,0,0,1,1));
    step(0, 4'd2, 5'd0);
    chk("fecha_fmt_off", ex(2,0,0,0,0,0,1));

    // switch drops on the cycle a repeat would fire
    for (int k = 0; k < 16; k++) begin
      logic e_inc;
      logic [3:0] s;
      s = (k >= RD + RR) ? 4'd0 : 4'd2;
      e_inc = (k == 0) || (AR && (k == RD));
      step(0, s, 5'd1);
      if (k >= RD + RR) chk($sformatf("drop_rel%0d", k + 1), ex(0,0,0,0,0,0,0));
      else              chk($sformatf("drop_rel%0d", k + 1), ex(2,0,e_inc,0,0,0,1));
    end
    step(0, 4'd0, 5'd0);
    chk("final_idle", ex(0,0,0,0,0,0,0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
